// File: rtl/port_link_if.sv
`default_nettype none
// ============================================================================
// Module      : port_link_if
// Description : Handshake bundle between two nodes joined by a port_link.
//               The write side carries words from the upstream node.
//               The read side carries words to the downstream node.
//   wr_data  [7:0]  upstream word offered to the link
//   wr_valid        upstream offers wr_data this cycle
//   wr_ready        link can accept a word this cycle
//   rd_data  [7:0]  word presented to the downstream node
//   rd_valid        rd_data holds a valid word
//   rd_ready        downstream consumes rd_data this cycle
//   modport master : the node pair around the link (drives wr_*, rd_ready)
//   modport slave  : the link itself
// Revision    : 1.0  initial release
// ============================================================================
interface port_link_if;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;

    modport master (
        output wr_data, wr_valid, rd_ready,
        input  wr_ready, rd_data, rd_valid
    );

    modport slave (
        input  wr_data, wr_valid, rd_ready,
        output wr_ready, rd_data, rd_valid
    );
endinterface
`default_nettype wire

// File: rtl/port_link.sv
`default_nettype none
// ============================================================================
// Module      : port_link
// Description : Point-to-point buffered link between two nodes.
//               It is a DEPTH-entry circular buffer with first-word
//               fall-through, plus a counter of upstream stall cycles.
//   clk            single clock
//   rst_n          asynchronous active-low reset
//   link (slave)   write-side and read-side handshake (port_link_if)
//   clr_stats      synchronous clear of stall_cnt
//   count [CNT_W]  number of words stored
//   stall_cnt[16]  saturating count of cycles with wr_valid=1 and wr_ready=0
// Revision    : 1.0  initial release
// ============================================================================
module port_link #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  wire              clk,
    input  wire              rst_n,
    port_link_if.slave       link,
    input  wire              clr_stats,
    output logic [CNT_W-1:0] count,
    output logic [15:0]      stall_cnt
);

    localparam int              c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_PTR_W-1:0] c_LAST = c_PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]   c_FULL = CNT_W'(DEPTH);

    logic [7:0]         mem_q [DEPTH];
    logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q,  count_d;
    logic [15:0]        stall_q,  stall_d;

    logic w_wr_ready;
    logic w_rd_valid;
    logic w_wr_fire;
    logic w_rd_fire;

    // Both flags come from the registered count only, so wr_ready has no
    // path from rd_ready: a full link refuses a write even while it is read.
    assign w_wr_ready = (count_q != c_FULL);
    assign w_rd_valid = (count_q != '0);
    assign w_wr_fire  = link.wr_valid && w_wr_ready;
    assign w_rd_fire  = link.rd_ready && w_rd_valid;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        stall_d  = stall_q;

        if (w_wr_fire) begin
            wr_ptr_d = (wr_ptr_q == c_LAST) ? '0 : wr_ptr_q + c_PTR_W'(1);
        end
        if (w_rd_fire) begin
            rd_ptr_d = (rd_ptr_q == c_LAST) ? '0 : rd_ptr_q + c_PTR_W'(1);
        end

        case ({w_wr_fire, w_rd_fire})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Clear wins over an increment in the same cycle.
        if (clr_stats) begin
            stall_d = '0;
        end else if (link.wr_valid && !w_wr_ready && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            stall_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            stall_q  <= stall_d;
        end
    end

    // Storage is left out of reset; clearing count alone hides stale words.
    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            mem_q[wr_ptr_q] <= link.wr_data;
        end
    end

    assign link.wr_ready = w_wr_ready;
    assign link.rd_valid = w_rd_valid;
    assign link.rd_data  = mem_q[rd_ptr_q];
    assign count         = count_q;
    assign stall_cnt     = stall_q;

endmodule
`default_nettype wire
